// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
// Module : sobel_pkg
// Brief  : Shared Sobel pipeline constants, pixel type and mask FSM states.
// Rev    : 1.0
// ============================================================================
package sobel_pkg;

    localparam int PIX_W      = 12;
    localparam int IMG_WIDTH  = 640;
    localparam int IMG_HEIGHT = 480;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } mask_state_t;

endpackage : sobel_pkg
`default_nettype wire

// File: rtl/sobel_pos_counter.sv
`default_nettype none
// ============================================================================
// Module : sobel_pos_counter
// Brief  : Column/row position of the current pixel with line wrap and row saturation.
// Rev    : 1.0
// ============================================================================
module sobel_pos_counter #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                          iCLK,
    input  logic                          rst_n,
    input  logic                          clear_i,
    input  logic                          adv_i,
    output logic [$clog2(IMG_WIDTH)-1:0]  col_o,
    output logic [$clog2(IMG_HEIGHT)-1:0] row_o,
    output logic                          row_ovf_o
);
    import sobel_pkg::*;

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] c_COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] c_ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0] col_q, col_d, col_base;
    logic [RW-1:0] row_q, row_d, row_base;
    logic          full_q, full_d, full_base;

    // A clear in the same cycle as an advance makes that pixel position (0,0).
    always_comb begin
        col_base  = clear_i ? '0 : col_q;
        row_base  = clear_i ? '0 : row_q;
        full_base = clear_i ? 1'b0 : full_q;
        col_d     = col_base;
        row_d     = row_base;
        full_d    = full_base;
        if (adv_i) begin
            if (col_base == c_COL_LAST) begin
                col_d = '0;
                if (row_base == c_ROW_LAST) begin
                    full_d = 1'b1;
                end else begin
                    row_d = row_base + 1'b1;
                end
            end else begin
                col_d = col_base + 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            full_q <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            full_q <= full_d;
        end
    end

    assign col_o     = col_base;
    assign row_o     = row_base;
    // Any pixel arriving after the last line has completed is one line too many.
    assign row_ovf_o = adv_i & full_base;

endmodule : sobel_pos_counter
`default_nettype wire

// File: rtl/sobel_border_mask.sv
`default_nettype none
// ============================================================================
// Module : sobel_border_mask
// Brief  : Masks incomplete-window border pixels, optional threshold, grey RGB out.
// Rev    : 1.0
// ============================================================================
module sobel_border_mask #(
    parameter int IMG_WIDTH  = sobel_pkg::IMG_WIDTH,
    parameter int IMG_HEIGHT = sobel_pkg::IMG_HEIGHT,
    parameter int PIX_W      = sobel_pkg::PIX_W
) (
    input  logic             iCLK,
    input  logic             rst_n,
    input  logic             iFVAL,
    input  logic             iDVAL,
    input  logic [PIX_W-1:0] iPixel,
    input  logic             iThreshEn,
    input  logic [PIX_W-1:0] iThresh,
    output logic             oDVAL,
    output logic [PIX_W-1:0] oRed,
    output logic [PIX_W-1:0] oGreen,
    output logic [PIX_W-1:0] oBlue,
    output logic             oFrameDone,
    output logic             oLineErr
);
    import sobel_pkg::*;

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] c_COL_LAST = CW'(IMG_WIDTH - 1);

    mask_state_t      state_q;
    logic             fval_q;
    logic             dval_q;
    logic [PIX_W-1:0] pix_q;
    logic             done_q;
    logic             err_q;

    logic [CW-1:0]    w_col;
    logic [RW-1:0]    w_row;
    logic             w_row_ovf;
    logic             w_start, w_end, w_pix, w_mid_line, w_masked;
    logic [PIX_W-1:0] w_value;

    assign w_start = (state_q == IDLE) & iFVAL & ~fval_q;
    assign w_end   = (state_q == ACTIVE) & ~iFVAL & fval_q;
    assign w_pix   = iDVAL & ((state_q == ACTIVE) | w_start);

    // Column position after this cycle's pixel (if any) has been counted.
    assign w_mid_line = iDVAL ? (w_col != c_COL_LAST) : (w_col != '0);

    assign w_masked = (w_col < CW'(2)) || (w_row < RW'(2));

    always_comb begin
        w_value = '0;
        if (!w_masked) begin
            if (iThreshEn) begin
                w_value = (iPixel >= iThresh) ? '1 : '0;
            end else begin
                w_value = iPixel;
            end
        end
    end

    sobel_pos_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT)
    ) u_pos (
        .iCLK      (iCLK),
        .rst_n     (rst_n),
        .clear_i   (w_start),
        .adv_i     (w_pix),
        .col_o     (w_col),
        .row_o     (w_row),
        .row_ovf_o (w_row_ovf)
    );

    // fval_q resets high so a frame already running at reset release is skipped.
    always_ff @(posedge iCLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fval_q  <= 1'b1;
            dval_q  <= 1'b0;
            pix_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            fval_q <= iFVAL;
            dval_q <= w_pix;
            done_q <= w_end;
            if (w_pix) begin
                pix_q <= w_value;
            end
            if (w_start) begin
                state_q <= ACTIVE;
            end else if (w_end) begin
                state_q <= IDLE;
            end
            if (w_row_ovf || (w_end && w_mid_line)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign oDVAL      = dval_q;
    assign oRed       = pix_q;
    assign oGreen     = pix_q;
    assign oBlue      = pix_q;
    assign oFrameDone = done_q;
    assign oLineErr   = err_q;

endmodule : sobel_border_mask
`default_nettype wire
